// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Byte-addressable, little-endian data memory built from 32-bit words.
//   Supports byte, halfword and word accesses. After reset it zeroes every
//   word, one per cycle, before raising ready.
//
// Ports
//   clock          : single clock, rising edge
//   reset_n        : asynchronous active-low reset
//   request_valid  : access presented this cycle
//   write_enable   : 1 = store, 0 = load
//   address[31:0]  : byte address
//   size[1:0]      : 00 byte, 01 halfword, 10 word, 11 illegal
//   load_unsigned  : zero-extend (1) / sign-extend (0) sub-word loads
//   in[31:0]       : store data, right-aligned
//   ready          : initialisation done, requests accepted
//   out[31:0]      : load result (held while out_valid=0)
//   out_valid      : out carries a new load result
//   misaligned     : one-cycle fault pulse
//   out_of_range   : one-cycle fault pulse
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        request_valid,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] in,
  output logic        ready,
  output logic [31:0] out,
  output logic        out_valid,
  output logic        misaligned,
  output logic        out_of_range
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int IW    = ADDR_WIDTH - 2;

  typedef enum logic {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     mem_q [WORDS];

  logic [31:0]     out_q;
  logic            out_valid_q;
  logic            misaligned_q;
  logic            out_of_range_q;

  logic            accept_s;
  logic            mis_s;
  logic            oor_s;
  logic            store_s;
  logic            load_s;
  logic [1:0]      lane_s;
  logic [IW-1:0]   widx_s;
  logic [3:0]      strb_s;
  logic [31:0]     wdata_s;
  logic [31:0]     rdword_s;
  logic [7:0]      rdbyte_s;
  logic [15:0]     rdhalf_s;
  logic [31:0]     load_data_s;

  assign ready    = (state_q == S_IDLE);
  assign accept_s = ready && request_valid;
  assign lane_s   = address[1:0];
  assign widx_s   = address[ADDR_WIDTH-1:2];
  // Any set bit above the decoded range is a fault.
  assign oor_s    = ((address >> ADDR_WIDTH) != 32'd0);
  assign store_s  = accept_s && write_enable && !mis_s && !oor_s;
  assign load_s   = accept_s && !write_enable && !mis_s && !oor_s;

  // Alignment check by access size
  always_comb begin
    mis_s = 1'b0;
    case (size)
      2'b00:   mis_s = 1'b0;
      2'b01:   mis_s = address[0];
      2'b10:   mis_s = (address[1:0] != 2'b00);
      default: mis_s = 1'b1;
    endcase
  end

  // Store lane strobes and data replicated onto every candidate lane
  always_comb begin
    strb_s  = 4'b0000;
    wdata_s = in;
    case (size)
      2'b00: begin
        strb_s  = 4'b0001 << lane_s;
        wdata_s = {4{in[7:0]}};
      end
      2'b01: begin
        strb_s  = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{in[15:0]}};
      end
      2'b10: begin
        strb_s  = 4'b1111;
        wdata_s = in;
      end
      default: begin
        strb_s  = 4'b0000;
        wdata_s = in;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    rdword_s = mem_q[widx_s];
    rdhalf_s = lane_s[1] ? rdword_s[31:16] : rdword_s[15:0];
    case (lane_s)
      2'b00:   rdbyte_s = rdword_s[7:0];
      2'b01:   rdbyte_s = rdword_s[15:8];
      2'b10:   rdbyte_s = rdword_s[23:16];
      default: rdbyte_s = rdword_s[31:24];
    endcase
    case (size)
      2'b00:   load_data_s = {{24{!load_unsigned && rdbyte_s[7]}}, rdbyte_s};
      2'b01:   load_data_s = {{16{!load_unsigned && rdhalf_s[15]}}, rdhalf_s};
      default: load_data_s = rdword_s;
    endcase
  end

  // Next-state logic: INIT walks idx across every word, then IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_INIT: begin
        idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
        if (idx_q == {IW{1'b1}}) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        state_d = S_IDLE;
        idx_d   = idx_q;
      end
      default: begin
        state_d = S_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // State and clear-index registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Memory array: cleared word by word in INIT, lane-masked stores in IDLE
  always_ff @(posedge clock) begin
    if (state_q == S_INIT) begin
      mem_q[idx_q] <= 32'd0;
    end else if (store_s) begin
      for (int l = 0; l < 4; l++) begin
        if (strb_s[l]) begin
          mem_q[widx_s][8*l +: 8] <= wdata_s[8*l +: 8];
        end
      end
    end
  end

  // Registered response: load data and single-cycle status pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q          <= 32'd0;
      out_valid_q    <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      out_valid_q    <= load_s;
      misaligned_q   <= accept_s && mis_s;
      out_of_range_q <= accept_s && oor_s;
      if (load_s) begin
        out_q <= load_data_s;
      end
    end
  end

  assign out          = out_q;
  assign out_valid    = out_valid_q;
  assign misaligned   = misaligned_q;
  assign out_of_range = out_of_range_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        request_valid;
  logic        write_enable;
  logic [31:0] address;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] din;
  logic        ready;
  logic [31:0] dout;
  logic        out_valid;
  logic        misaligned;
  logic        out_of_range;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;
  bit pulse;

  always #5 clock = ~clock;

  data_memory #(.ADDR_WIDTH(10)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .request_valid (request_valid),
    .write_enable  (write_enable),
    .address       (address),
    .size          (size),
    .load_unsigned (load_unsigned),
    .in            (din),
    .ready         (ready),
    .out           (dout),
    .out_valid     (out_valid),
    .misaligned    (misaligned),
    .out_of_range  (out_of_range)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic [31:0] exp_out, input logic exp_ov,
                            input logic exp_mis, input logic exp_oor);
    check({tag, ".out"}, dout, exp_out);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
    check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, exp_mis});
    check({tag, ".out_of_range"}, {31'd0, out_of_range}, {31'd0, exp_oor});
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                     input logic lu, input logic [31:0] d);
    request_valid = 1'b1;
    write_enable  = we;
    address       = a;
    size          = sz;
    load_unsigned = lu;
    din           = d;
    @(posedge clock);
    #1;
    request_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    request_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Counts edges until ready (bounded); optionally presents requests meanwhile.
  task automatic wait_ready(input bit drive, input int limit, output int n, output bit p);
    n = 0;
    p = 1'b0;
    while (ready !== 1'b1 && n < limit) begin
      if (drive) begin
        request_valid = 1'b1;
        write_enable  = (n < 20);
        address       = (n < 20) ? 32'h0000_0008 : 32'h0000_0402;
        size          = 2'b10;
        load_unsigned = 1'b0;
        din           = 32'hFFFF_FFFF;
      end
      @(posedge clock);
      #1;
      n++;
      if (out_valid || misaligned || out_of_range) p = 1'b1;
    end
    request_valid = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    request_valid = 1'b0;
    write_enable  = 1'b0;
    address       = 32'd0;
    size          = 2'b10;
    load_unsigned = 1'b0;
    din           = 32'd0;

    repeat (3) @(posedge clock);
    #1;
    check("rst.ready", {31'd0, ready}, 32'd0);
    check_resp("rst", 32'd0, 1'b0, 1'b0, 1'b0);

    // Release and count the clearing window
    reset_n = 1'b1;
    wait_ready(1'b0, 400, edges, pulse);
    check("init.edges", edges, 32'd256);
    check("init.ready", {31'd0, ready}, 32'd1);

    req(1'b0, 32'h3FC, 2'b10, 1'b0, 32'd0);
    check_resp("ld_3fc", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);

    // Word store then byte loads
    req(1'b1, 32'h10, 2'b10, 1'b0, 32'h80FF_7F01);
    check_resp("st_10", 32'h0, 1'b0, 1'b0, 1'b0);
    req(1'b0, 32'h10, 2'b00, 1'b0, 32'd0);
    check_resp("lb_10", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h11, 2'b00, 1'b0, 32'd0);
    check_resp("lb_11", 32'h0000_007F, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h12, 2'b00, 1'b0, 32'd0);
    check_resp("lb_12", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h13, 2'b00, 1'b0, 32'd0);
    check_resp("lb_13", 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h12, 2'b00, 1'b1, 32'd0);
    check_resp("lbu_12", 32'h0000_00FF, 1'b1, 1'b0, 1'b0);

    // Halfword merge into an existing word
    req(1'b1, 32'h20, 2'b10, 1'b0, 32'h1122_3344);
    req(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_BEEF);
    check_resp("sh_22", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    req(1'b0, 32'h20, 2'b10, 1'b0, 32'd0);
    check_resp("lw_20", 32'hBEEF_3344, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h22, 2'b01, 1'b0, 32'd0);
    check_resp("lh_22", 32'hFFFF_BEEF, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h20, 2'b01, 1'b1, 32'd0);
    check_resp("lhu_20", 32'h0000_3344, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    check_resp("hold", 32'h0000_3344, 1'b0, 1'b0, 1'b0);

    // Faults
    req(1'b1, 32'h21, 2'b10, 1'b0, 32'hDEAD_BEEF);
    check_resp("sw_21", 32'h0000_3344, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    check_resp("sw_21.after", 32'h0000_3344, 1'b0, 1'b0, 1'b0);
    req(1'b1, 32'h20, 2'b11, 1'b0, 32'hDEAD_BEEF);
    check_resp("sz11", 32'h0000_3344, 1'b0, 1'b1, 1'b0);
    req(1'b0, 32'h23, 2'b01, 1'b0, 32'd0);
    check_resp("lh_23", 32'h0000_3344, 1'b0, 1'b1, 1'b0);
    req(1'b1, 32'h400, 2'b10, 1'b0, 32'hDEAD_BEEF);
    check_resp("sw_400", 32'h0000_3344, 1'b0, 1'b0, 1'b1);
    req(1'b0, 32'h402, 2'b10, 1'b0, 32'd0);
    check_resp("lw_402", 32'h0000_3344, 1'b0, 1'b1, 1'b1);
    req(1'b0, 32'h20, 2'b10, 1'b0, 32'd0);
    check_resp("lw_20.unchanged", 32'hBEEF_3344, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h0, 2'b10, 1'b0, 32'd0);
    check_resp("lw_0.unchanged", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Back-to-back store/load, and top word boundary
    req(1'b1, 32'h8, 2'b10, 1'b0, 32'hCAFE_F00D);
    req(1'b0, 32'h8, 2'b10, 1'b0, 32'd0);
    check_resp("b2b_8", 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    req(1'b1, 32'h3FC, 2'b10, 1'b0, 32'hA5A5_5A5A);
    req(1'b0, 32'h3FF, 2'b00, 1'b0, 32'd0);
    check_resp("lb_3ff", 32'hFFFF_FFA5, 1'b1, 1'b0, 1'b0);

    // Reset with a load result just registered
    request_valid = 1'b1;
    write_enable  = 1'b0;
    address       = 32'h8;
    size          = 2'b10;
    @(posedge clock);
    #1;
    request_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_resp("rst_inflight", 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_inflight.ready", {31'd0, ready}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Partial INIT with requests ignored, then reset again mid-INIT
    wait_ready(1'b1, 100, edges, pulse);
    check("midinit.edges", edges, 32'd100);
    check("midinit.ready", {31'd0, ready}, 32'd0);
    check("midinit.pulse", {31'd0, pulse}, 32'd0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_ready(1'b1, 400, edges, pulse);
    check("reinit.edges", edges, 32'd256);
    check("reinit.pulse", {31'd0, pulse}, 32'd0);

    req(1'b0, 32'h8, 2'b10, 1'b0, 32'd0);
    check_resp("lw_8.cleared", 32'h0, 1'b1, 1'b0, 1'b0);
    req(1'b0, 32'h3FC, 2'b10, 1'b0, 32'd0);
    check_resp("lw_3fc.cleared", 32'h0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning byte-address bits decoded (capacity 2**ADDR_WIDTH bytes, ADDR_WIDTH >= 3).
REQ-002 SHALL have derived constant WORDS = 2**(ADDR_WIDTH-2), meaning 32-bit word entries.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port request_valid, input, 1, meaning an access is presented this cycle.
REQ-006 SHALL have port write_enable, input, 1, meaning 1 = store and 0 = load, when request_valid=1.
REQ-007 SHALL have port address, input, 32, meaning byte address.
REQ-008 SHALL have port size, input, 2, meaning 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port load_unsigned, input, 1, meaning zero-extend (1) or sign-extend (0) byte/halfword loads.
REQ-010 SHALL have port in, input, 32, meaning store data, right-aligned.
REQ-011 SHALL have port ready, output, 1, meaning initialisation complete and requests accepted.
REQ-012 SHALL have port out, output, 32, meaning load result.
REQ-013 SHALL have port out_valid, output, 1, meaning out carries a new load result.
REQ-014 SHALL have port misaligned, output, 1, meaning one-cycle fault pulse.
REQ-015 SHALL have port out_of_range, output, 1, meaning one-cycle fault pulse.

Function
REQ-016 SHALL store data little-endian: byte at address A in word A[ADDR_WIDTH-1:2], lane A[1:0].
REQ-017 SHALL implement a two-state FSM: INIT (write zero to word index idx, idx increments 0..WORDS-1) and IDLE; INIT -> IDLE after the cycle writing idx=WORDS-1.
REQ-018 SHALL drive ready=1 only in IDLE; requests with ready=0 are ignored (no memory change, no output pulses).
REQ-019 SHALL accept a request when ready=1 and request_valid=1; one request per cycle, no backpressure.
REQ-020 SHALL flag misaligned when size=01 and A[0]=1, size=10 and A[1:0]!=0, or size=11.
REQ-021 SHALL flag out_of_range when address[31:ADDR_WIDTH] != 0.
REQ-022 SHALL, for a faulting request, leave memory unchanged, assert the applicable flag(s) (both if both apply) in the following cycle for one cycle, and keep out_valid=0.
REQ-023 SHALL, on a non-faulting store, update only the addressed lanes at the accepting edge: byte in[7:0] to lane A[1:0]; halfword in[15:0] to lanes A[1]*2..+1; word all four lanes.
REQ-024 SHALL, on a non-faulting load, present the result on out with out_valid=1 exactly one cycle after acceptance; byte/halfword extracted from the lane(s) per REQ-016 and extended per load_unsigned.
REQ-025 SHALL hold out at its last value when out_valid=0; stores never assert out_valid.
REQ-026 SHALL return, for a load to an address stored in the immediately preceding cycle, the newly stored data.
REQ-027 SHALL not assert out_valid, misaligned or out_of_range in the same cycle for different requests; each pulse belongs to the request accepted one cycle earlier.

Reset
REQ-028 SHALL, while reset_n=0, force state=INIT, idx=0, ready=0, out=0, out_valid=0, misaligned=0, out_of_range=0.
REQ-029 SHALL, on reset asserted mid-INIT or mid-IDLE, discard any in-flight load result and restart clearing from idx=0 after release.
REQ-030 SHALL have ready rise exactly WORDS cycles after the first clock edge following reset_n release; memory reads all-zero thereafter.

Verification
REQ-031 SHALL cover: reset release, ADDR_WIDTH=10 -> ready=0 for 256 edges, then 1; word load at 0x3FC -> out=0x00000000, out_valid one cycle later.
REQ-032 SHALL cover: word store 0x80FF7F01 at 0x10; byte loads 0x10..0x13 signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; load_unsigned=1 at 0x12 -> 0x000000FF.
REQ-033 SHALL cover: halfword store 0xBEEF at 0x22 over word 0x11223344 at 0x20 -> word load at 0x20 = 0xBEEF3344; signed halfword load at 0x22 = 0xFFFFBEEF.
REQ-034 SHALL cover: word store at 0x21 and size=11 -> misaligned=1 one cycle, memory unchanged; store at 0x400 -> out_of_range=1; word load at 0x402 -> both flags, out_valid=0.
REQ-035 SHALL cover: back-to-back store 0xCAFEF00D at 0x8 then load at 0x8 -> out=0xCAFEF00D next cycle; request while ready=0 -> no pulse.
REQ-036 SHALL cover: reset_n pulsed low mid-INIT and with a load in flight -> no out_valid, ready low for a full WORDS cycles again.
